tft_reg_bank: RTL and testbench

Register bank sitting directly downstream of the SPI slave interface. It consumes the decoded reg_addr/reg_wdata/reg_write/reg_read transactions and returns reg_rdata. It holds the TFT leakage-control configuration (enable, mode, bias code), issues one-cycle command pulses and collects sticky event flags into a maskable interrupt. Write access to the configuration registers is guarded by an unlock key.

---
 rtl/tft_reg_pkg.sv | 35 +++
 rtl/tft_irq_flags.sv | 29 ++
 rtl/tft_reg_bank.sv | 128 ++++++++++++
 tb/tb_tft_reg_bank.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/tft_reg_pkg.sv
// Shared register map, CTRL field layout and unlock key for the TFT leakage-control register bank.
package tft_reg_pkg;

  localparam logic [7:0] ADDR_ID         = 8'h00;
  localparam logic [7:0] ADDR_CTRL       = 8'h04;
  localparam logic [7:0] ADDR_STATUS     = 8'h08;
  localparam logic [7:0] ADDR_INT_STATUS = 8'h0C;
  localparam logic [7:0] ADDR_INT_MASK   = 8'h10;
  localparam logic [7:0] ADDR_CMD        = 8'h14;
  localparam logic [7:0] ADDR_BIAS       = 8'h18;
  localparam logic [7:0] ADDR_SCRATCH    = 8'h1C;
  localparam logic [7:0] ADDR_LOCK       = 8'h20;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_W   = 3;

  localparam logic [31:0] UNLOCK_KEY = 32'h0000_A5A5;

  localparam int INT_W       = 8;
  localparam int INT_ERR_BIT = 7;

  typedef struct packed {
    logic [CTRL_MODE_W-1:0] mode;
    logic                   enable;
  } ctrl_t;

  function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
    ctrl_t c;
    c.enable = w[CTRL_EN_BIT];
    c.mode   = w[CTRL_MODE_LSB +: CTRL_MODE_W];
    return c;
  endfunction

endpackage

// File: rtl/tft_irq_flags.sv
// Sticky event flags with write-1-to-clear, an interrupt mask and a registered irq.
module tft_irq_flags #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  input  logic             mask_we,
  input  logic [WIDTH-1:0] mask_wdata,
  output logic [WIDTH-1:0] flags,
  output logic [WIDTH-1:0] mask,
  output logic             irq
);

  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
      mask  <= '0;
      irq   <= 1'b0;
    end else begin
      // set is OR-ed after the clear so a simultaneous event survives W1C
      flags <= (flags & ~clr) | set;
      if (mask_we) mask <= mask_wdata;
      irq <= |(flags & mask);
    end
  end

endmodule

// File: rtl/tft_reg_bank.sv
// Register bank behind the SPI slave: lockable leakage-control config, command pulses,
// sticky event flags with maskable irq, and a registered read mux.
module tft_reg_bank
  import tft_reg_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h5446_5401,
  parameter int          N_EVT    = 7,
  parameter logic [11:0] BIAS_MAX = 12'd3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  input  logic             reg_write,
  input  logic             reg_read,
  output logic [31:0]      reg_rdata,
  input  logic [N_EVT-1:0] evt_i,
  input  logic [15:0]      status_i,
  output logic             ctrl_enable,
  output logic [2:0]       ctrl_mode,
  output logic [11:0]      bias_code,
  output logic             cmd_start,
  output logic             cmd_abort,
  output logic             irq
);

  ctrl_t       ctrl_q;
  logic [11:0] bias_q;
  logic [31:0] scratch_q;
  logic [15:0] status_q;
  logic        lock_q;

  logic wr_ctrl, wr_int, wr_mask, wr_cmd, wr_bias, wr_scratch, wr_lock, acc_err;
  logic [INT_W-1:0] flags, mask, flag_set, flag_clr;
  logic [11:0] bias_next;
  logic [31:0] rd_mux;

  // Reads have no side effects, so the strobe is intentionally not consumed.
  logic unused_reg_read;
  assign unused_reg_read = reg_read;

  always_comb begin
    wr_ctrl    = 1'b0;
    wr_int     = 1'b0;
    wr_mask    = 1'b0;
    wr_cmd     = 1'b0;
    wr_bias    = 1'b0;
    wr_scratch = 1'b0;
    wr_lock    = 1'b0;
    acc_err    = 1'b0;
    if (reg_write) begin
      case (reg_addr)
        ADDR_ID, ADDR_STATUS: acc_err = 1'b1;
        ADDR_CTRL:            if (lock_q) acc_err = 1'b1; else wr_ctrl = 1'b1;
        ADDR_INT_STATUS:      wr_int = 1'b1;
        ADDR_INT_MASK:        wr_mask = 1'b1;
        ADDR_CMD:             wr_cmd = 1'b1;
        ADDR_BIAS:            if (lock_q) acc_err = 1'b1; else wr_bias = 1'b1;
        ADDR_SCRATCH:         wr_scratch = 1'b1;
        ADDR_LOCK:            wr_lock = 1'b1;
        default:              acc_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    flag_set              = '0;
    flag_set[N_EVT-1:0]   = evt_i;
    flag_set[INT_ERR_BIT] = acc_err;
    flag_clr              = wr_int ? reg_wdata[INT_W-1:0] : '0;
  end

  // Saturation compares the full write word, so large values with zero low bits still clamp.
  assign bias_next = (reg_wdata > {20'h0, BIAS_MAX}) ? BIAS_MAX : reg_wdata[11:0];

  always_comb begin
    case (reg_addr)
      ADDR_ID:         rd_mux = ID_VALUE;
      ADDR_CTRL:       rd_mux = {28'h0, ctrl_q};
      ADDR_STATUS:     rd_mux = {16'h0, status_q};
      ADDR_INT_STATUS: rd_mux = {24'h0, flags};
      ADDR_INT_MASK:   rd_mux = {24'h0, mask};
      ADDR_BIAS:       rd_mux = {20'h0, bias_q};
      ADDR_SCRATCH:    rd_mux = scratch_q;
      ADDR_LOCK:       rd_mux = {31'h0, lock_q};
      default:         rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q    <= '0;
      bias_q    <= '0;
      scratch_q <= '0;
      status_q  <= '0;
      lock_q    <= 1'b1;
      cmd_start <= 1'b0;
      cmd_abort <= 1'b0;
      reg_rdata <= '0;
    end else begin
      status_q  <= status_i;
      reg_rdata <= rd_mux;
      cmd_start <= wr_cmd & reg_wdata[0] & ~reg_wdata[1];
      cmd_abort <= wr_cmd & reg_wdata[1];
      if (wr_ctrl)    ctrl_q    <= ctrl_from_word(reg_wdata);
      if (wr_bias)    bias_q    <= bias_next;
      if (wr_scratch) scratch_q <= reg_wdata;
      if (wr_lock)    lock_q    <= (reg_wdata != UNLOCK_KEY);
    end
  end

  tft_irq_flags #(.WIDTH(INT_W)) u_irq_flags (
    .clk        (clk),
    .rst        (rst),
    .set        (flag_set),
    .clr        (flag_clr),
    .mask_we    (wr_mask),
    .mask_wdata (reg_wdata[INT_W-1:0]),
    .flags      (flags),
    .mask       (mask),
    .irq        (irq)
  );

  assign ctrl_enable = ctrl_q.enable;
  assign ctrl_mode   = ctrl_q.mode;
  assign bias_code   = bias_q;

endmodule

// File: tb/tb_tft_reg_bank.sv
// Directed bench for tft_reg_bank: a register-map model checked every cycle plus literal expectations.
module tb_tft_reg_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_write;
  logic        reg_read;
  logic [31:0] reg_rdata;
  logic [6:0]  evt_i;
  logic [15:0] status_i;
  logic        ctrl_enable;
  logic [2:0]  ctrl_mode;
  logic [11:0] bias_code;
  logic        cmd_start;
  logic        cmd_abort;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  tft_reg_bank dut (
    .clk         (clk),
    .rst         (rst),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_write   (reg_write),
    .reg_read    (reg_read),
    .reg_rdata   (reg_rdata),
    .evt_i       (evt_i),
    .status_i    (status_i),
    .ctrl_enable (ctrl_enable),
    .ctrl_mode   (ctrl_mode),
    .bias_code   (bias_code),
    .cmd_start   (cmd_start),
    .cmd_abort   (cmd_abort),
    .irq         (irq)
  );

  // Model state: stored register words by word index, plus expected registered outputs.
  logic [31:0] m_word [0:8];
  logic        m_locked;
  logic [15:0] m_stat;
  logic [7:0]  m_flags, m_mask, m_clr;
  logic        m_err;
  logic [31:0] e_rdata;
  logic        e_irq, e_start, e_abort;

  function automatic logic [31:0] m_read(input logic [7:0] a);
    if (a[1:0] != 2'b00 || a > 8'h20) return 32'h0;
    case (a >> 2)
      0: return 32'h5446_5401;
      1: return {28'h0, m_word[1][3:0]};
      2: return {16'h0, m_stat};
      3: return {24'h0, m_flags};
      4: return {24'h0, m_mask};
      6: return {20'h0, m_word[6][11:0]};
      7: return m_word[7];
      8: return {31'h0, m_locked};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) m_word[i] = 32'h0;
      m_locked = 1'b1; m_stat = 16'h0; m_flags = 8'h0; m_mask = 8'h0;
      e_rdata = 32'h0; e_irq = 1'b0; e_start = 1'b0; e_abort = 1'b0;
    end else begin
      e_rdata = m_read(reg_addr);
      e_irq   = |(m_flags & m_mask);
      e_start = 1'b0; e_abort = 1'b0; m_err = 1'b0; m_clr = 8'h0;
      if (reg_write) begin
        if (reg_addr[1:0] != 2'b00 || reg_addr > 8'h20) m_err = 1'b1;
        else case (reg_addr >> 2)
          0, 2: m_err = 1'b1;
          1:    if (m_locked) m_err = 1'b1; else m_word[1] = reg_wdata;
          3:    m_clr = reg_wdata[7:0];
          4:    m_mask = reg_wdata[7:0];
          5:    begin e_abort = reg_wdata[1]; e_start = reg_wdata[0] && !reg_wdata[1]; end
          6:    if (m_locked) m_err = 1'b1;
                else m_word[6] = (reg_wdata > 32'd3000) ? 32'd3000 : reg_wdata;
          7:    m_word[7] = reg_wdata;
          default: m_locked = (reg_wdata != 32'h0000_A5A5);
        endcase
      end
      m_flags = (m_flags & ~m_clr) | {m_err, evt_i};
      m_stat  = status_i;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata", reg_rdata, e_rdata);
      chk("ctrl_enable", {31'h0, ctrl_enable}, {31'h0, m_word[1][0]});
      chk("ctrl_mode", {29'h0, ctrl_mode}, {29'h0, m_word[1][3:1]});
      chk("bias_code", {20'h0, bias_code}, {20'h0, m_word[6][11:0]});
      chk("cmd_start", {31'h0, cmd_start}, {31'h0, e_start});
      chk("cmd_abort", {31'h0, cmd_abort}, {31'h0, e_abort});
      chk("irq", {31'h0, irq}, {31'h0, e_irq});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    reg_addr = a; reg_read = 1'b1;
    tick();
    reg_read = 1'b0;
    d = reg_rdata;
  endtask

  logic [31:0] d;

  initial begin
    rst = 1'b1; reg_addr = 8'h0; reg_wdata = 32'h0; reg_write = 1'b0; reg_read = 1'b0;
    evt_i = 7'h0; status_i = 16'h1234;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    chk("reset_outputs", {ctrl_enable, ctrl_mode, bias_code, cmd_start, cmd_abort, irq}, 32'h0);
    rd(8'h00, d); chk("id_read", d, 32'h5446_5401);
    rd(8'h20, d); chk("lock_after_reset", d, 32'h1);

    wr(8'h04, 32'h0000_0007);
    chk("ctrl_locked_enable", {31'h0, ctrl_enable}, 32'h0);
    rd(8'h0C, d); chk("locked_write_err", d, 32'h80);

    wr(8'h20, 32'h0000_A5A5);
    rd(8'h20, d); chk("unlocked", d, 32'h0);
    wr(8'h04, 32'h0000_0007);
    chk("ctrl_enable", {31'h0, ctrl_enable}, 32'h1);
    chk("ctrl_mode", {29'h0, ctrl_mode}, 32'h3);
    rd(8'h04, d); chk("ctrl_read", d, 32'h7);

    wr(8'h18, 32'h0000_1000); chk("bias_sat_1000", {20'h0, bias_code}, 32'd3000);
    wr(8'h18, 32'h0001_0005); chk("bias_sat_high", {20'h0, bias_code}, 32'd3000);
    wr(8'h18, 32'd42);        chk("bias_42", {20'h0, bias_code}, 32'd42);
    wr(8'h18, 32'd3000);      chk("bias_eq_max", {20'h0, bias_code}, 32'd3000);
    wr(8'h18, 32'd2999);      chk("bias_2999", {20'h0, bias_code}, 32'd2999);
    wr(8'h18, 32'd3001);      chk("bias_max_plus1", {20'h0, bias_code}, 32'd3000);

    wr(8'h14, 32'h3);
    chk("cmd3_abort", {31'h0, cmd_abort}, 32'h1);
    chk("cmd3_start", {31'h0, cmd_start}, 32'h0);
    tick();
    chk("cmd3_abort_end", {31'h0, cmd_abort}, 32'h0);
    wr(8'h14, 32'h1);
    chk("cmd1_start", {31'h0, cmd_start}, 32'h1);
    tick();
    chk("cmd1_start_end", {31'h0, cmd_start}, 32'h0);
    rd(8'h14, d); chk("cmd_reads_zero", d, 32'h0);

    wr(8'h1C, 32'hDEAD_BEEF);
    rd(8'h1C, d); chk("scratch", d, 32'hDEAD_BEEF);

    wr(8'h0C, 32'hFF);
    wr(8'h10, 32'h01);
    evt_i = 7'h01; tick(); evt_i = 7'h00;
    chk("irq_not_yet", {31'h0, irq}, 32'h0);
    tick();
    chk("irq_set", {31'h0, irq}, 32'h1);
    evt_i = 7'h01; wr(8'h0C, 32'h01); evt_i = 7'h00;
    rd(8'h0C, d); chk("w1c_vs_set", d, 32'h01);
    wr(8'h0C, 32'h01);
    tick();
    chk("irq_cleared", {31'h0, irq}, 32'h0);
    rd(8'h0C, d); chk("flag_cleared", d, 32'h0);

    evt_i = 7'h40; tick(); evt_i = 7'h00;
    rd(8'h0C, d); chk("masked_evt_sticky", d, 32'h40);
    chk("masked_no_irq", {31'h0, irq}, 32'h0);
    wr(8'h0C, 32'hFF);

    status_i = 16'hBEEF; tick();
    rd(8'h08, d); chk("status_sample", d, 32'h0000_BEEF);
    wr(8'h44, 32'h1234_5678);
    rd(8'h0C, d); chk("unmapped_err", d, 32'h80);
    wr(8'h0C, 32'h80);
    wr(8'h08, 32'hFFFF_FFFF);
    rd(8'h08, d); chk("status_ro", d, 32'h0000_BEEF);
    rd(8'h0C, d); chk("ro_write_err", d, 32'h80);
    rd(8'h44, d); chk("unmapped_read", d, 32'h0);

    wr(8'h10, 32'h80);
    tick();
    chk("irq_err_masked_on", {31'h0, irq}, 32'h1);

    wr(8'h20, 32'h0000_0001);
    wr(8'h18, 32'd7);
    chk("relocked_bias", {20'h0, bias_code}, 32'd3000);

    wr(8'h20, 32'h0000_A5A5);
    wr(8'h14, 32'h2);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_outputs", {ctrl_enable, ctrl_mode, bias_code, cmd_start, cmd_abort, irq}, 32'h0);
    rd(8'h20, d); chk("rst_lock", d, 32'h1);
    rd(8'h1C, d); chk("rst_scratch", d, 32'h0);
    rd(8'h10, d); chk("rst_mask", d, 32'h0);
    rd(8'h0C, d); chk("rst_flags", d, 32'h0);

    tick(); tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
